// File: rtl/spi_slave_wide.sv
// spi_slave_wide: parametrised SPI slave, any CPOL/CPHA, WIDTH-bit words.
// SPI pins are synchronised into clk; tx words arrive over valid/ready.
module spi_slave_wide #(
    parameter int unsigned      WIDTH     = 8,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b0,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] FILL      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned OUT = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {IDLE, SHIFT} state_e;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    logic [2:0]       sclk_q, ss_q;
    logic [1:0]       mosi_q, vld_q;
    logic             armed_q, armed_d;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic             miso_q, miso_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             unr_q, unr_d;

    logic             sclk_chg, lead_e, trail_e, sample_e, shift_e;
    logic             ss_rise, ss_fall, last, load;
    logic [WIDTH-1:0] rx_next, load_word;

    assign sclk_chg  = sclk_q[1] ^ sclk_q[2];
    assign lead_e    = sclk_chg && (sclk_q[1] != CPOL);
    assign trail_e   = sclk_chg && (sclk_q[1] == CPOL);
    assign sample_e  = CPHA ? trail_e : lead_e;
    assign shift_e   = CPHA ? lead_e : trail_e;
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign rx_next   = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], mosi_q[1]}
                                 : {mosi_q[1], rx_sr_q[WIDTH-1:1]};
    assign load_word = full_q ? hold_q : FILL;

    // armed blocks a start from an ss level that was already high out of reset
    assign armed_d = armed_q | (vld_q[1] & ~ss_q[1]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        hold_d     = hold_q;
        full_d     = full_q;
        unr_d      = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_rise && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    miso_d  = 1'b0;
                    rx_sr_d = '0;
                end else begin
                    if (sample_e) begin
                        rx_sr_d = rx_next;
                        cnt_d   = last ? '0 : cnt_q + 1'b1;
                        if (last) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            if (CPHA) load = 1'b1;
                            else done_d = 1'b1;
                        end
                    end
                    if (shift_e) begin
                        if (!CPHA && done_q) begin
                            load   = 1'b1;
                            done_d = 1'b0;
                        end else begin
                            miso_d  = tx_sr_q[OUT];
                            tx_sr_d = advance(tx_sr_q);
                        end
                    end
                end
            end
        endcase
        if (load) begin
            full_d = 1'b0;
            unr_d  = !full_q;
            if (CPHA) begin
                tx_sr_d = load_word;
            end else begin
                miso_d  = load_word[OUT];
                tx_sr_d = advance(load_word);
            end
        end
        // an accept in a load cycle only happens when the holder was empty
        if (tx_valid && !full_q) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q     <= '0;
            ss_q       <= '0;
            mosi_q     <= '0;
            vld_q      <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_sr_q    <= '0;
            miso_q     <= 1'b0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            unr_q      <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], sclk};
            ss_q       <= {ss_q[1:0], ss};
            mosi_q     <= {mosi_q[0], mosi};
            vld_q      <= {vld_q[0], 1'b1};
            armed_q    <= armed_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_sr_q    <= tx_sr_d;
            miso_q     <= miso_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            unr_q      <= unr_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == SHIFT);
    assign busy        = (state_q == SHIFT);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~full_q;
    assign tx_underrun = unr_q;

endmodule

// File: tb/tb_spi_slave_wide.sv
// tb_spi_slave_wide: directed bench driving six spi_slave_wide configurations
// from one bit-banged SPI master; instance 1 is WIDTH=16, the rest WIDTH=8.
module tb_spi_slave_wide;

    localparam int HALF = 6;
    localparam logic [5:0] CPOL_M = 6'b011000;
    localparam logic [5:0] CPHA_M = 6'b010100;
    localparam logic [5:0] MSB_M  = 6'b011111;

    logic clk = 1'b0;
    logic rst;
    logic sclk, mosi;
    logic [5:0] ss_v, txv_v;
    logic [15:0] txd;
    logic [5:0] miso_v, oe_v, rxv_v, rdy_v, unr_v, busy_v;
    logic [5:0][15:0] rxd;

    int n_chk = 0;
    int n_err = 0;
    int rxv_cnt [6];
    int unr_cnt [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : gen_dut
        localparam int W = (g == 1) ? 16 : 8;
        spi_slave_wide #(
            .WIDTH(W), .CPOL(CPOL_M[g]), .CPHA(CPHA_M[g]), .MSB_FIRST(MSB_M[g])
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk), .ss(ss_v[g]), .mosi(mosi),
            .miso(miso_v[g]), .miso_oe(oe_v[g]), .rx_data(rxd[g][W-1:0]),
            .rx_valid(rxv_v[g]), .tx_data(txd[W-1:0]), .tx_valid(txv_v[g]),
            .tx_ready(rdy_v[g]), .tx_underrun(unr_v[g]), .busy(busy_v[g])
        );
        if (W < 16) begin : gen_pad
            assign rxd[g][15:W] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 6; g++) begin
            if (rxv_v[g]) rxv_cnt[g]++;
            if (unr_v[g]) unr_cnt[g]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input int g, input logic [15:0] d);
        int n;
        n = 0;
        while (!rdy_v[g] && n < 5000) begin
            wclk(1);
            n++;
        end
        chk("push_rdy", {31'd0, rdy_v[g]}, 1);
        txd = d;
        txv_v[g] = 1'b1;
        wclk(1);
        txv_v[g] = 1'b0;
    endtask

    task automatic ss_on(input int g);
        sclk = CPOL_M[g];
        wclk(8);
        ss_v[g] = 1'b1;
        wclk(8);
    endtask

    task automatic ss_off(input int g);
        wclk(8);
        ss_v[g] = 1'b0;
        wclk(8);
    endtask

    task automatic xfer(input int g, input logic [15:0] mo, input int nb,
                        output logic [15:0] mi);
        int w, b;
        logic cpol, cpha, msb;
        w = (g == 1) ? 16 : 8;
        cpol = CPOL_M[g];
        cpha = CPHA_M[g];
        msb = MSB_M[g];
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            b = msb ? w - 1 - i : i;
            if (!cpha) begin
                mosi = mo[b];
                wclk(HALF);
                mi[b] = miso_v[g];
                sclk = ~cpol;
                wclk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[b];
                wclk(HALF);
                mi[b] = miso_v[g];
                sclk = cpol;
                wclk(HALF);
            end
        end
    endtask

    initial begin
        logic [15:0] mi;
        int r0, u0;
        int sweep [5];
        sweep = '{0, 2, 3, 4, 5};
        rst = 1'b0;
        sclk = 1'b0;
        mosi = 1'b0;
        ss_v = '0;
        txv_v = '0;
        txd = '0;
        wclk(4);
        rst = 1'b1;
        wclk(4);
        chk("rst_rx", {16'd0, rxd[0]}, 0);
        chk("rst_rdy", {31'd0, rdy_v[0]}, 1);
        chk("rst_oe", {31'd0, oe_v[0]}, 0);
        chk("rst_busy", {31'd0, busy_v[0]}, 0);

        push_tx(0, 16'h003C);
        chk("m0_rdy_full", {31'd0, rdy_v[0]}, 0);
        r0 = rxv_cnt[0];
        ss_on(0);
        chk("m0_rdy_load", {31'd0, rdy_v[0]}, 1);
        chk("m0_oe", {31'd0, oe_v[0]}, 1);
        chk("m0_busy", {31'd0, busy_v[0]}, 1);
        xfer(0, 16'h00A5, 8, mi);
        ss_off(0);
        chk("m0_miso", {16'd0, mi}, 32'h3C);
        chk("m0_rx", {16'd0, rxd[0]}, 32'hA5);
        chk("m0_rxv", rxv_cnt[0] - r0, 1);
        chk("m0_idle", {31'd0, busy_v[0]}, 0);

        push_tx(0, 16'h0011);
        r0 = rxv_cnt[0];
        ss_on(0);
        push_tx(0, 16'h0022);
        chk("rs_full", {31'd0, rdy_v[0]}, 0);
        xfer(0, 16'h00C3, 3, mi);
        rst = 1'b0;
        wclk(1);
        chk("rs_rx", {16'd0, rxd[0]}, 0);
        chk("rs_rxv", {31'd0, rxv_v[0]}, 0);
        chk("rs_rdy", {31'd0, rdy_v[0]}, 1);
        chk("rs_unr", {31'd0, unr_v[0]}, 0);
        chk("rs_miso", {31'd0, miso_v[0]}, 0);
        chk("rs_oe", {31'd0, oe_v[0]}, 0);
        chk("rs_busy", {31'd0, busy_v[0]}, 0);
        wclk(1);
        rst = 1'b1;
        wclk(12);
        chk("rs_no_start", {31'd0, busy_v[0]}, 0);
        ss_v[0] = 1'b0;
        wclk(8);
        ss_on(0);
        xfer(0, 16'h005A, 8, mi);
        ss_off(0);
        chk("rs_rx_new", {16'd0, rxd[0]}, 32'h5A);
        chk("rs_rxv_cnt", rxv_cnt[0] - r0, 1);

        r0 = rxv_cnt[0];
        u0 = unr_cnt[0];
        ss_on(0);
        chk("ur_pulse", unr_cnt[0] - u0, 1);
        xfer(0, 16'h0077, 8, mi);
        ss_off(0);
        chk("ur_miso", {16'd0, mi}, 0);
        chk("ur_rx", {16'd0, rxd[0]}, 32'h77);
        chk("ur_rxv", rxv_cnt[0] - r0, 1);

        r0 = rxv_cnt[0];
        ss_on(0);
        xfer(0, 16'h00FF, 5, mi);
        ss_off(0);
        chk("ab_rxv", rxv_cnt[0] - r0, 0);
        chk("ab_oe", {31'd0, oe_v[0]}, 0);
        chk("ab_miso", {31'd0, miso_v[0]}, 0);
        ss_on(0);
        xfer(0, 16'h0081, 8, mi);
        ss_off(0);
        chk("ab_rx", {16'd0, rxd[0]}, 32'h81);
        chk("ab_rxv2", rxv_cnt[0] - r0, 1);

        push_tx(1, 16'h1000);
        r0 = rxv_cnt[1];
        u0 = unr_cnt[1];
        ss_on(1);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(1, 16'(i), 16, mi);
                    chk("w16_miso", {16'd0, mi}, 32'h1000 + i);
                    chk("w16_rx", {16'd0, rxd[1]}, i);
                    chk("w16_rxv", rxv_cnt[1] - r0, i + 1);
                end
            end
            begin
                for (int i = 1; i < 5; i++) push_tx(1, 16'h1000 + 16'(i));
            end
        join
        ss_off(1);
        chk("w16_unr", unr_cnt[1] - u0, 0);

        foreach (sweep[k]) begin
            push_tx(sweep[k], 16'h0080);
            sclk = CPOL_M[sweep[k]];
            wclk(512);
            r0 = rxv_cnt[sweep[k]];
            ss_on(sweep[k]);
            xfer(sweep[k], 16'h0001, 8, mi);
            ss_off(sweep[k]);
            chk($sformatf("sw%0d_miso", sweep[k]), {16'd0, mi}, 32'h80);
            chk($sformatf("sw%0d_rx", sweep[k]), {16'd0, rxd[sweep[k]]}, 1);
            chk($sformatf("sw%0d_rxv", sweep[k]), rxv_cnt[sweep[k]] - r0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
